// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit_pkg
// Description : Shared constants and state encoding for the IF-stage PC
//               redirect unit (reset vector, PC stride, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_unit_pkg;

  // Architectural address bus width
  localparam int ADDR_BUS = 32;

  // Boot vector loaded by reset
  localparam logic [ADDR_BUS-1:0] C_RESET_PC = 32'hBFC0_0000;

  // Sequential fetch stride (one 32-bit instruction)
  localparam logic [ADDR_BUS-1:0] C_PC_INC = 32'd4;

  // Redirect FSM: IDLE = normal fetch, PEND = target buffered behind delay slot
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage : pc_redirect_unit_pkg
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Owns the IF-stage program counter. Applies exception flushes,
//               taken branches with one MIPS delay slot (buffering the target
//               while the delay-slot fetch is stalled) and sequential fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              fetch_ready,
  input  logic              id_advance,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] exc_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pc_misaligned,
  output logic              branch_pending
);

  localparam logic [ADDR_W-1:0] c_pc_inc = ADDR_W'(C_PC_INC);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt;
  state_e            r_state;
  logic              r_rom_en;
  logic              r_misaligned;

  logic              w_adv;
  logic              w_take;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_tgt_nxt;
  state_e            w_state_nxt;

  // A fetch can only complete once one has been issued; this keeps the first
  // cycle after reset on RESET_PC even when the ROM reports ready.
  assign w_adv  = fetch_ready & ~stall_if & r_rom_en;
  assign w_take = branch_flag & id_advance;

  // Next-PC selection: flush > buffered-target release > branch > sequential
  always_comb begin
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_state_nxt = r_state;
    if (flush) begin
      w_pc_nxt    = exc_pc;
      w_tgt_nxt   = '0;
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_PEND) begin
      // Delay-slot fetch finishing releases the buffered target; a branch
      // request here is illegal and never overwrites the target.
      if (w_adv) begin
        w_pc_nxt    = r_tgt;
        w_state_nxt = ST_IDLE;
      end
    end else if (w_take) begin
      if (w_adv) begin
        w_pc_nxt = branch_addr;
      end else begin
        w_tgt_nxt   = branch_addr;
        w_state_nxt = ST_PEND;
      end
    end else if (w_adv) begin
      w_pc_nxt = r_pc + c_pc_inc;
    end
  end

  // Register PC, target buffer, state and the registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_tgt        <= '0;
      r_state      <= ST_IDLE;
      r_rom_en     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      assert (!((r_state == ST_PEND) && w_take));
      r_pc         <= w_pc_nxt;
      r_tgt        <= w_tgt_nxt;
      r_state      <= w_state_nxt;
      r_rom_en     <= 1'b1;
      r_misaligned <= |w_pc_nxt[1:0];
    end
  end

  assign pc             = r_pc;
  assign rom_addr       = r_pc;
  assign rom_en         = r_rom_en;
  assign pc_misaligned  = r_misaligned;
  assign branch_pending = (r_state == ST_PEND);

endmodule : pc_redirect_unit
`default_nettype wire
